// File: rtl/guess_game_ctrl.sv
// Multi-level number-guessing game controller: FSM, LFSR target source,
// timed show/answer phases, lives and level tracking with registered outputs.
module guess_game_ctrl #(
   parameter int          LEVELS   = 3,
   parameter int          BASE_W   = 5,
   parameter longint      SHOW_CYC = 50_000_000,
   parameter longint      PLAY_CYC = 250_000_000,
   parameter int          LIVES    = 3,
   parameter logic [15:0] SEED     = 16'hACE1,
   localparam int         W        = BASE_W + LEVELS - 1,
   localparam int         LW       = $clog2(LEVELS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          go,
   input  logic          restart,
   input  logic [W-1:0]  sw,
   output logic [W-1:0]  led,
   output logic [LW-1:0] level,
   output logic [3:0]    lives,
   output logic [31:0]   time_left,
   output logic [2:0]    state,
   output logic          ok_pulse,
   output logic          fail_pulse,
   output logic          win,
   output logic          lose
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READY = 3'd1,
      S_SHOW  = 3'd2,
      S_PLAY  = 3'd3,
      S_JUDGE = 3'd4,
      S_WIN   = 3'd5,
      S_LOSE  = 3'd6
   } state_t;

   localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [3:0]    LIVES_V  = 4'(LIVES);
   localparam logic [LW-1:0] LAST_LVL = LW'(LEVELS - 1);
   localparam logic [31:0]   SHOW_END = 32'(SHOW_CYC - 1);
   localparam logic [31:0]   PLAY_TL  = 32'(PLAY_CYC);

   state_t        st_reg;
   logic [15:0]   lfsr_reg;
   logic [W-1:0]  target_reg;
   logic [31:0]   show_cnt_reg;
   logic          verdict_reg;
   logic          lfsr_fb;
   logic [LW-1:0] level_up;
   logic [W-1:0]  tgt_same;
   logic [W-1:0]  tgt_up;
   logic [W-1:0]  tgt_zero;
   logic          answer_ok;

   function automatic logic [W-1:0] mask_of(input logic [LW-1:0] k);
      logic [W-1:0] m;
      m = '0;
      for (int i = 0; i < W; i++) begin
         if (i < BASE_W + int'(k)) m[i] = 1'b1;
      end
      return m;
   endfunction

   assign lfsr_fb   = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
   assign level_up  = level + LW'(1);
   assign tgt_same  = lfsr_reg[W-1:0] & mask_of(level);
   assign tgt_up    = lfsr_reg[W-1:0] & mask_of(level_up);
   assign tgt_zero  = lfsr_reg[W-1:0] & mask_of('0);
   assign answer_ok = ((sw & mask_of(level)) == target_reg);
   assign state     = st_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         st_reg       <= S_IDLE;
         lfsr_reg     <= SEED_EFF;
         target_reg   <= '0;
         show_cnt_reg <= '0;
         verdict_reg  <= 1'b0;
         level        <= '0;
         lives        <= '0;
         time_left    <= '0;
         led          <= '0;
         ok_pulse     <= 1'b0;
         fail_pulse   <= 1'b0;
         win          <= 1'b0;
         lose         <= 1'b0;
      end else begin
         lfsr_reg   <= {lfsr_reg[14:0], lfsr_fb};
         ok_pulse   <= 1'b0;
         fail_pulse <= 1'b0;
         if (!en) begin
            st_reg       <= S_IDLE;
            show_cnt_reg <= '0;
            verdict_reg  <= 1'b0;
            level        <= '0;
            lives        <= '0;
            time_left    <= '0;
            led          <= '0;
            win          <= 1'b0;
            lose         <= 1'b0;
         end else if (restart || st_reg == S_IDLE ||
                      ((st_reg == S_WIN || st_reg == S_LOSE) && go)) begin
            // Every path into READY starts a fresh game.
            st_reg       <= S_READY;
            show_cnt_reg <= '0;
            level        <= '0;
            lives        <= LIVES_V;
            time_left    <= '0;
            led          <= '0;
            win          <= 1'b0;
            lose         <= 1'b0;
         end else begin
            case (st_reg)
               S_READY: begin
                  if (go) begin
                     st_reg       <= S_SHOW;
                     target_reg   <= tgt_zero;
                     led          <= tgt_zero;
                     show_cnt_reg <= '0;
                  end
               end
               S_SHOW: begin
                  if (show_cnt_reg == SHOW_END) begin
                     st_reg    <= S_PLAY;
                     led       <= '0;
                     time_left <= PLAY_TL;
                  end else begin
                     show_cnt_reg <= show_cnt_reg + 32'd1;
                  end
               end
               S_PLAY: begin
                  // A go on the last answer cycle is still judged on sw.
                  if (go) begin
                     st_reg      <= S_JUDGE;
                     verdict_reg <= answer_ok;
                     ok_pulse    <= answer_ok;
                     fail_pulse  <= !answer_ok;
                     time_left   <= '0;
                  end else if (time_left <= 32'd1) begin
                     st_reg      <= S_JUDGE;
                     verdict_reg <= 1'b0;
                     fail_pulse  <= 1'b1;
                     time_left   <= '0;
                  end else begin
                     time_left <= time_left - 32'd1;
                  end
               end
               S_JUDGE: begin
                  show_cnt_reg <= '0;
                  if (verdict_reg) begin
                     if (level == LAST_LVL) begin
                        st_reg <= S_WIN;
                        win    <= 1'b1;
                        led    <= '1;
                     end else begin
                        st_reg     <= S_SHOW;
                        level      <= level_up;
                        target_reg <= tgt_up;
                        led        <= tgt_up;
                     end
                  end else if (lives <= 4'd1) begin
                     st_reg <= S_LOSE;
                     lives  <= '0;
                     lose   <= 1'b1;
                     led    <= '0;
                  end else begin
                     st_reg     <= S_SHOW;
                     lives      <= lives - 4'd1;
                     target_reg <= tgt_same;
                     led        <= tgt_same;
                  end
               end
               S_WIN, S_LOSE: begin
               end
               default: st_reg <= S_IDLE;
            endcase
         end
      end
   end

endmodule
